// File: rtl/mode_decoder_reg.sv
// Launchpad mode decoder: synchronises the three one-hot mode lines, filters them for
// stability and publishes a registered mode code, LED vector, valid flag and change strobe.
module mode_decoder_reg #(
    parameter int unsigned STABLE_CYCLES = 4,   // 1..15
    parameter bit          HOLD_ON_IDLE  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mod_1,
    input  logic       mod_2,
    input  logic       mod_3,
    output logic [1:0] mode_code,
    output logic [2:0] mode_led,
    output logic       mode_valid,
    output logic       mode_change
);

    localparam logic [3:0] CNT_MAX  = 4'(STABLE_CYCLES);
    localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);

    typedef enum logic {
        S_NONE   = 1'b0,
        S_LOCKED = 1'b1
    } state_e;

    logic [2:0] sync1_q, sync2_q;
    logic [1:0] sync_code;
    logic [1:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic       commit_ok, has_target, do_commit;
    logic [1:0] target;
    state_e     state_q, state_d;
    logic [1:0] mode_code_q, mode_code_d;
    logic [2:0] mode_led_q, mode_led_d;
    logic       mode_valid_q, mode_valid_d;
    logic       mode_change_q, mode_change_d;

    // Two-flop synchroniser; bit order is {mod_3, mod_2, mod_1}.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {mod_3, mod_2, mod_1};
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        unique case (sync2_q)
            3'b001:  sync_code = 2'b01;
            3'b010:  sync_code = 2'b10;
            3'b100:  sync_code = 2'b11;
            default: sync_code = 2'b00;
        endcase
    end

    // Stability filter: any disagreement with the candidate restarts the count.
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (sync_code != cand_q) begin
            cand_d = sync_code;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    assign commit_ok  = (sync_code == cand_q) && (cnt_q == CNT_LAST);
    assign target     = cand_q;
    assign has_target = (cand_q != 2'b00) || !HOLD_ON_IDLE;
    assign do_commit  = commit_ok && has_target && (target != mode_code_q);

    always_comb begin
        state_d       = state_q;
        mode_code_d   = mode_code_q;
        mode_led_d    = mode_led_q;
        mode_change_d = 1'b0;
        if (do_commit) begin
            mode_code_d   = target;
            mode_change_d = 1'b1;
            unique case (target)
                2'b01:   mode_led_d = 3'b001;
                2'b10:   mode_led_d = 3'b010;
                2'b11:   mode_led_d = 3'b100;
                default: mode_led_d = 3'b000;
            endcase
            unique case (state_q)
                S_NONE:   if (target != 2'b00) state_d = S_LOCKED;
                S_LOCKED: if (target == 2'b00) state_d = S_NONE;
                default:  state_d = S_NONE;
            endcase
        end
        mode_valid_d = (state_d == S_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q        <= '0;
            cnt_q         <= '0;
            state_q       <= S_NONE;
            mode_code_q   <= '0;
            mode_led_q    <= '0;
            mode_valid_q  <= 1'b0;
            mode_change_q <= 1'b0;
        end else begin
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            mode_code_q   <= mode_code_d;
            mode_led_q    <= mode_led_d;
            mode_valid_q  <= mode_valid_d;
            mode_change_q <= mode_change_d;
        end
    end

    assign mode_code   = mode_code_q;
    assign mode_led    = mode_led_q;
    assign mode_valid  = mode_valid_q;
    assign mode_change = mode_change_q;

endmodule

// File: tb/tb_mode_decoder_reg.sv
// Directed bench for mode_decoder_reg: three instances (default, HOLD_ON_IDLE=0,
// STABLE_CYCLES=1) share stimulus; a step table plus hand-written latency/reset sequences.
module tb_mode_decoder_reg;

    logic clk = 1'b0;
    logic rst_n;
    logic mod_1, mod_2, mod_3;

    logic [1:0] code_a, code_b, code_c;
    logic [2:0] led_a, led_b, led_c;
    logic       valid_a, valid_b, valid_c;
    logic       chg_a, chg_b, chg_c;

    int tests  = 0;
    int failed = 0;
    int str_a  = 0;
    int str_b  = 0;
    int str_c  = 0;

    always #5 clk = ~clk;

    mode_decoder_reg dut_a (
        .clk(clk), .rst_n(rst_n), .mod_1(mod_1), .mod_2(mod_2), .mod_3(mod_3),
        .mode_code(code_a), .mode_led(led_a), .mode_valid(valid_a), .mode_change(chg_a)
    );

    mode_decoder_reg #(.STABLE_CYCLES(4), .HOLD_ON_IDLE(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .mod_1(mod_1), .mod_2(mod_2), .mod_3(mod_3),
        .mode_code(code_b), .mode_led(led_b), .mode_valid(valid_b), .mode_change(chg_b)
    );

    mode_decoder_reg #(.STABLE_CYCLES(1), .HOLD_ON_IDLE(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .mod_1(mod_1), .mod_2(mod_2), .mod_3(mod_3),
        .mode_code(code_c), .mode_led(led_c), .mode_valid(valid_c), .mode_change(chg_c)
    );

    typedef struct {
        logic [2:0] mods;     // {mod_3, mod_2, mod_1}
        int         cycles;
        logic [1:0] code_a;
        int         str_a;
        logic [1:0] code_b;
        int         str_b;
        logic [1:0] code_c;
        int         str_c;
    } step_t;

    step_t steps [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] led_of(input logic [1:0] code);
        case (code)
            2'b01:   return 3'b001;
            2'b10:   return 3'b010;
            2'b11:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // One rising edge; outputs are sampled 1 time unit later and strobes accumulated.
    task automatic tick();
        @(posedge clk);
        #1;
        str_a += int'(chg_a);
        str_b += int'(chg_b);
        str_c += int'(chg_c);
    endtask

    task automatic drive(input logic [2:0] m);
        {mod_3, mod_2, mod_1} = m;
    endtask

    initial begin
        int sa, sb, sc;

        steps[0] = '{3'b100,  3, 2'b01, 0, 2'b01, 0, 2'b01, 0};  // glitch to mode3
        steps[1] = '{3'b001, 10, 2'b01, 0, 2'b01, 0, 2'b01, 2};  // restore mode1
        steps[2] = '{3'b011, 20, 2'b01, 0, 2'b00, 1, 2'b01, 0};  // invalid combination
        steps[3] = '{3'b010,  6, 2'b01, 0, 2'b00, 0, 2'b10, 1};  // direct switch, edges 1..6
        steps[4] = '{3'b010,  1, 2'b10, 1, 2'b10, 1, 2'b10, 0};  // edge 7 commits
        steps[5] = '{3'b010, 50, 2'b10, 0, 2'b10, 0, 2'b10, 0};  // saturation, no strobes
        steps[6] = '{3'b000, 20, 2'b10, 0, 2'b00, 1, 2'b10, 0};  // idle
        steps[7] = '{3'b100, 20, 2'b11, 1, 2'b11, 1, 2'b11, 1};  // mode3 from either state

        // Reset with mod_1 held, then exact commit edge.
        rst_n = 1'b0;
        drive(3'b001);
        repeat (3) tick();
        check("rst_code_a", 32'(code_a), 32'd0);
        check("rst_led_a", 32'(led_a), 32'd0);
        check("rst_valid_a", 32'(valid_a), 32'd0);
        check("rst_chg_a", 32'(chg_a), 32'd0);
        check("rst_code_b", 32'(code_b), 32'd0);
        check("rst_code_c", 32'(code_c), 32'd0);
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e < 7) begin
                check($sformatf("m1_pre_code_e%0d", e), 32'(code_a), 32'd0);
                check($sformatf("m1_pre_chg_e%0d", e), 32'(chg_a), 32'd0);
            end else if (e == 7) begin
                check("m1_code", 32'(code_a), 32'd1);
                check("m1_led", 32'(led_a), 32'b001);
                check("m1_valid", 32'(valid_a), 32'd1);
                check("m1_chg", 32'(chg_a), 32'd1);
                check("m1_code_b", 32'(code_b), 32'd1);
                check("m1_chg_b", 32'(chg_b), 32'd1);
            end else begin
                check("m1_chg_width", 32'(chg_a), 32'd0);
                check("m1_code_hold", 32'(code_a), 32'd1);
            end
            if (e == 3) check("sc1_pre_code", 32'(code_c), 32'd0);
            if (e == 4) begin
                check("sc1_code", 32'(code_c), 32'd1);
                check("sc1_chg", 32'(chg_c), 32'd1);
            end
        end
        repeat (5) tick();

        for (int i = 0; i < 8; i++) begin
            sa = str_a;
            sb = str_b;
            sc = str_c;
            drive(steps[i].mods);
            repeat (steps[i].cycles) tick();
            check($sformatf("s%0d_code_a", i), 32'(code_a), 32'(steps[i].code_a));
            check($sformatf("s%0d_led_a", i), 32'(led_a), 32'(led_of(steps[i].code_a)));
            check($sformatf("s%0d_valid_a", i), 32'(valid_a), 32'(steps[i].code_a != 2'b00));
            check($sformatf("s%0d_strobes_a", i), 32'(str_a - sa), 32'(steps[i].str_a));
            check($sformatf("s%0d_code_b", i), 32'(code_b), 32'(steps[i].code_b));
            check($sformatf("s%0d_led_b", i), 32'(led_b), 32'(led_of(steps[i].code_b)));
            check($sformatf("s%0d_valid_b", i), 32'(valid_b), 32'(steps[i].code_b != 2'b00));
            check($sformatf("s%0d_strobes_b", i), 32'(str_b - sb), 32'(steps[i].str_b));
            check($sformatf("s%0d_code_c", i), 32'(code_c), 32'(steps[i].code_c));
            check($sformatf("s%0d_led_c", i), 32'(led_c), 32'(led_of(steps[i].code_c)));
            check($sformatf("s%0d_strobes_c", i), 32'(str_c - sc), 32'(steps[i].str_c));
        end

        // Reset in the middle of filtering mod_3.
        drive(3'b001);
        repeat (20) tick();
        check("pre_mid_code_a", 32'(code_a), 32'd1);
        drive(3'b100);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_code_a", 32'(code_a), 32'd0);
        check("mid_rst_led_a", 32'(led_a), 32'd0);
        check("mid_rst_valid_a", 32'(valid_a), 32'd0);
        check("mid_rst_chg_a", 32'(chg_a), 32'd0);
        check("mid_rst_code_b", 32'(code_b), 32'd0);
        check("mid_rst_code_c", 32'(code_c), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 4) check("mid_c_code", 32'(code_c), 32'd3);
            if (e == 6) check("mid_pre_code_a", 32'(code_a), 32'd0);
            if (e == 7) begin
                check("mid_code_a", 32'(code_a), 32'd3);
                check("mid_led_a", 32'(led_a), 32'b100);
                check("mid_chg_a", 32'(chg_a), 32'd1);
                check("mid_code_b", 32'(code_b), 32'd3);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
